// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO that feeds an external combinational ALU4 and captures results in an output register.
// Define ALU_CMD_QUEUE_STATS_EN to build the saturating op_count counter; otherwise op_count is tied to 0.
module alu_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [3:0] in_a,
  input  logic signed [3:0] in_b,
  input  logic        [2:0] in_ctl,
  output logic signed [3:0] alu_a,
  output logic signed [3:0] alu_b,
  output logic        [2:0] alu_ctl,
  input  logic        [3:0] alu_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic        [3:0] out_z,
  output logic        [2:0] out_ctl,
  output logic              out_zero,
  output logic        [7:0] op_count
);
  localparam int AW = $clog2(DEPTH);
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          r_out_valid, r_out_zero;
  logic [3:0]    r_out_z;
  logic [2:0]    r_out_ctl;
  logic          w_push, w_pop, w_busy;
  logic [10:0]   w_head;
  assign w_busy   = r_cnt != '0;
  assign in_ready = r_cnt < (AW+1)'(DEPTH);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = w_busy && (!r_out_valid || out_ready);
  assign w_head   = w_busy ? r_mem[r_rd] : '0;
  assign {alu_ctl, alu_a, alu_b} = w_head;
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_ctl   = r_out_ctl;
  assign out_zero  = r_out_zero;
  // Storage is never reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {in_ctl, in_a, in_b};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_ctl   <= '0;
      r_out_zero  <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_z     <= alu_z;
        r_out_ctl   <= w_head[10:8];
        r_out_zero  <= alu_z == 4'b0000;
      end else if (out_ready) r_out_valid <= 1'b0;
    end
`ifdef ALU_CMD_QUEUE_STATS_EN
  logic [7:0] r_op_count;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_op_count <= '0;
    else if (r_out_valid && out_ready && r_op_count != 8'hff) r_op_count <= r_op_count + 1'b1;
  assign op_count = r_op_count;
`else
  assign op_count = '0;
`endif
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: randomized self-checking bench for alu_cmd_queue with a queue-based reference model
// and a behavioural ALU4 closing the loop on alu_a/alu_b/alu_ctl -> alu_z.
module tb_alu_cmd_queue;
  localparam int DEPTH = 4;
`ifdef ALU_CMD_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {logic [2:0] c; logic [3:0] a; logic [3:0] b;} cmd_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic in_valid = 1'b0, in_ready, out_ready = 1'b0;
  logic signed [3:0] in_a = '0, in_b = '0, alu_a, alu_b;
  logic [2:0] in_ctl = '0, alu_ctl, out_ctl;
  logic [3:0] alu_z, out_z;
  logic out_valid, out_zero;
  logic [7:0] op_count;
  int checks = 0, errors = 0;
  cmd_t q[$];
  bit m_ov = 1'b0, m_ozero = 1'b0;
  logic [3:0] m_oz = '0;
  logic [2:0] m_octl = '0;
  int m_cnt = 0;

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctl(in_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_ctl(out_ctl), .out_zero(out_zero), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu4(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return ~(a & b);
      3'd2:    return a | b;
      3'd4:    return a - b;
      3'd7:    return ~(a ^ b);
      default: return a ^ b ^ {1'b0, c};
    endcase
  endfunction

  assign alu_z = alu4(alu_ctl, alu_a, alu_b);

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.c = 3'($urandom_range(0, 7));
    c.a = 4'($urandom_range(0, 15));
    c.b = 4'($urandom_range(0, 15));
    return c;
  endfunction

  // Drive one cycle of inputs, advance the model across the rising edge, return at the next falling edge.
  task automatic step(input bit v, input cmd_t c, input bit r);
    bit push, pop;
    cmd_t h;
    in_valid = v; in_ctl = c.c; in_a = c.a; in_b = c.b; out_ready = r;
    push = v && q.size() < DEPTH;
    pop  = q.size() > 0 && (!m_ov || r);
    if (STATS && m_ov && r && m_cnt != 255) m_cnt++;
    @(posedge clk);
    if (pop) begin
      h = q.pop_front();
      m_oz = alu4(h.c, h.a, h.b); m_octl = h.c; m_ozero = m_oz == 4'd0; m_ov = 1'b1;
    end else if (r) m_ov = 1'b0;
    if (push) q.push_back(c);
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete(); m_ov = 1'b0; m_oz = '0; m_octl = '0; m_ozero = 1'b0; m_cnt = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({out_z, out_ctl, out_zero} !== 8'd0) begin errors++; $display("FAIL reset_out_regs got %h exp 0", {out_z, out_ctl, out_zero}); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
    checks++; if ({alu_ctl, alu_a, alu_b} !== 11'd0) begin errors++; $display("FAIL reset_alu_drive got %h exp 0", {alu_ctl, alu_a, alu_b}); end
    @(negedge clk); rstn = 1'b1; model_reset();
  endtask

  task automatic test_basic_add();
    step(1'b1, '{3'd0, 4'd3, 4'd5}, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early got %b exp 0", out_valid); end
    checks++; if ({alu_ctl, alu_a, alu_b} !== {3'd0, 4'd3, 4'd5}) begin errors++; $display("FAIL add_alu_drive got %h exp %h", {alu_ctl, alu_a, alu_b}, {3'd0, 4'd3, 4'd5}); end
    step(1'b0, '{3'd0, 4'd0, 4'd0}, 1'b1);
    checks++; if ({out_valid, out_z, out_ctl, out_zero} !== {1'b1, 4'b1000, 3'd0, 1'b0}) begin errors++; $display("FAIL add_result got v=%b z=%b ctl=%0d zero=%b exp v=1 z=1000 ctl=0 zero=0", out_valid, out_z, out_ctl, out_zero); end
    step(1'b0, '{3'd0, 4'd0, 4'd0}, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_clear got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    cmd_t cs[4];
    cs[0] = '{3'd4, 4'd5, 4'd5}; cs[1] = '{3'd1, 4'hf, 4'hf};
    cs[2] = '{3'd2, 4'h0, 4'h0}; cs[3] = '{3'd7, 4'ha, 4'h5};
    for (int i = 0; i < 6; i++) begin
      step(i < 4, i < 4 ? cs[i] : cs[0], 1'b1);
      if (i >= 1 && i <= 4) begin
        checks++;
        if ({out_valid, out_z, out_zero, out_ctl} !== {1'b1, 4'd0, 1'b1, cs[i-1].c}) begin errors++; $display("FAIL b2b_result_%0d got v=%b z=%b zero=%b ctl=%0d exp v=1 z=0000 zero=1 ctl=%0d", i-1, out_valid, out_z, out_zero, out_ctl, cs[i-1].c); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
  endtask

  task automatic fill5(output cmd_t cs[5]);
    for (int i = 0; i < 5; i++) begin
      cs[i] = rnd_cmd();
      step(1'b1, cs[i], 1'b0);
    end
  endtask

  task automatic test_backpressure();
    cmd_t cs[5];
    fill5(cs);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, rnd_cmd(), 1'b0);
      checks++; if ({out_valid, out_z, out_ctl} !== {1'b1, alu4(cs[0].c, cs[0].a, cs[0].b), cs[0].c}) begin errors++; $display("FAIL bp_hold_%0d got v=%b z=%h ctl=%0d exp v=1 z=%h ctl=%0d", k, out_valid, out_z, out_ctl, alu4(cs[0].c, cs[0].a, cs[0].b), cs[0].c); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready_%0d got %b exp 0", k, in_ready); end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, cs[0], 1'b1);
      if (i < 4) begin
        checks++; if ({out_valid, out_z, out_ctl} !== {1'b1, alu4(cs[i+1].c, cs[i+1].a, cs[i+1].b), cs[i+1].c}) begin errors++; $display("FAIL bp_drain_%0d got v=%b z=%h ctl=%0d exp v=1 z=%h ctl=%0d", i+1, out_valid, out_z, out_ctl, alu4(cs[i+1].c, cs[i+1].a, cs[i+1].b), cs[i+1].c); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_end got %b exp 0", out_valid); end
      end
    end
  endtask

  task automatic test_full_push();
    cmd_t cs[5];
    int seen;
    fill5(cs);
    step(1'b1, '{3'd0, 4'd7, 4'd7}, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_push_ready got %b exp 1", in_ready); end
    checks++; if ({out_valid, out_ctl, out_z} !== {1'b1, cs[1].c, alu4(cs[1].c, cs[1].a, cs[1].b)}) begin errors++; $display("FAIL full_push_pop got ctl=%0d z=%h exp ctl=%0d z=%h", out_ctl, out_z, cs[1].c, alu4(cs[1].c, cs[1].a, cs[1].b)); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, cs[0], 1'b1);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 3) begin errors++; $display("FAIL full_push_no_push got %0d results exp 3", seen); end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rnd_cmd(), 1'b0);
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b exp 1", in_ready); end
    #1; rstn = 1'b1; model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, rnd_cmd(), 1'b1);
      checks++; if ({out_valid, in_ready, alu_ctl, alu_a, alu_b} !== {2'b01, 11'd0}) begin errors++; $display("FAIL rst_mid_stale_%0d got v=%b rdy=%b head=%h exp v=0 rdy=1 head=0", i, out_valid, in_ready, {alu_ctl, alu_a, alu_b}); end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_head;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rnd_cmd(), $urandom_range(0, 2) != 0);
      exp_head = q.size() > 0 ? {q[0].c, q[0].a, q[0].b} : 11'd0;
      checks++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready@%0d got %b exp %b", i, in_ready, q.size() < DEPTH); end
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid@%0d got %b exp %b", i, out_valid, m_ov); end
      if (m_ov) begin
        checks++; if ({out_z, out_ctl, out_zero} !== {m_oz, m_octl, m_ozero}) begin errors++; $display("FAIL rnd_result@%0d got z=%h ctl=%0d zero=%b exp z=%h ctl=%0d zero=%b", i, out_z, out_ctl, out_zero, m_oz, m_octl, m_ozero); end
      end
      checks++; if ({alu_ctl, alu_a, alu_b} !== exp_head) begin errors++; $display("FAIL rnd_alu_drive@%0d got %h exp %h", i, {alu_ctl, alu_a, alu_b}, exp_head); end
      checks++; if (op_count !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_op_count@%0d got %0d exp %0d", i, op_count, m_cnt); end
    end
  endtask

  task automatic test_stats();
    for (int i = 0; i < 300; i++) step(1'b1, rnd_cmd(), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, rnd_cmd(), 1'b1);
    checks++; if (op_count !== (STATS ? 8'd255 : 8'd0)) begin errors++; $display("FAIL stats_final got %0d exp %0d", op_count, STATS ? 255 : 0); end
    checks++; if (op_count !== 8'(m_cnt)) begin errors++; $display("FAIL stats_model got %0d exp %0d", op_count, m_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_backpressure();
    test_full_push();
    test_midstream_reset();
    test_random();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 DEPTH, 4, number of command FIFO entries; legal values are 2, 4 and 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a command is offered.
REQ-005 in_ready  output  1  the queue can accept a command.
REQ-006 in_a, in_b  input  4 each  signed operands.
REQ-007 in_ctl  input  3  ALU opcode: 0 ADD, 1 NAND, 2 OR, 4 SUB, 7 XNOR.
REQ-008 alu_a, alu_b  output  4 each  operands driven to the downstream combinational ALU4.
REQ-009 alu_ctl  output  3  opcode driven to ALU4.
REQ-010 alu_z  input  4  combinational result returned from ALU4.
REQ-011 out_valid  output  1  a result is held in the output register.
REQ-012 out_ready  input  1  the consumer takes the result.
REQ-013 out_z  output  4  registered result.
REQ-014 out_ctl  output  3  opcode that produced out_z.
REQ-015 out_zero  output  1  set when out_z is 4'b0000.
REQ-016 op_count  output  8  count of completed operations (see Configuration).

Function
REQ-017 A push SHALL occur on a rising edge where in_valid and in_ready are both high; {in_ctl, in_a, in_b} is written at the write pointer.
REQ-018 in_ready SHALL be high exactly when occupancy < DEPTH; a pop in the same cycle does not raise in_ready (no bypass).
REQ-019 While occupancy > 0, alu_a, alu_b and alu_ctl SHALL drive the head entry; when empty they SHALL drive 0.
REQ-020 A pop SHALL occur when occupancy > 0 and (out_valid is low or out_ready is high).
REQ-021 On a pop, the output register SHALL load out_z <= alu_z, out_ctl <= head ctl, out_zero <= (alu_z == 0), and out_valid <= 1.
REQ-022 If out_ready is high with no pop, out_valid SHALL clear on that edge.
REQ-023 While out_valid is high and out_ready is low, out_z, out_ctl and out_zero SHALL hold stable and no pop occurs.
REQ-024 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers advance.
REQ-025 Pointers SHALL wrap modulo DEPTH, and occupancy SHALL use log2(DEPTH)+1 bits.
REQ-026 Latency: a command pushed at edge N into an empty queue with the output free SHALL produce out_valid after edge N+1.
REQ-027 Throughput with out_ready held high SHALL be one result per cycle.
REQ-028 Opcodes 3, 5 and 6 SHALL be queued and issued unchanged; the result is whatever ALU4 returns.
REQ-029 Commands SHALL complete in strict FIFO order, with no drop or duplication.

Reset
REQ-030 rstn low SHALL asynchronously clear the pointers, occupancy, out_valid, out_z, out_ctl and op_count to 0, and set out_zero to 0.
REQ-031 FIFO storage need not be cleared on reset.
REQ-032 A reset asserted mid-stream SHALL discard all queued and held results, and in_ready SHALL be 1 on the first edge after release.

Configuration
REQ-033 The macro ALU_CMD_QUEUE_STATS_EN SHALL control the op_count statistics counter.
REQ-034 With ALU_CMD_QUEUE_STATS_EN defined, op_count SHALL increment by 1 on every edge where out_valid and out_ready are both high, and saturate at 255.
REQ-035 Without ALU_CMD_QUEUE_STATS_EN, op_count SHALL be constant 0 and no counter logic is built.

Verification
REQ-036 Basic ADD: push a=3, b=5, ctl=0 with out_ready=1 -> out_valid one edge later with out_z=1000, out_ctl=0, out_zero=0.
REQ-037 Back-to-back stream: push SUB(5,5), NAND(1111,1111), OR(0000,0000), XNOR(1010,0101) with out_ready=1 -> four consecutive results 0000, 0000, 0000, 0000, all with out_zero=1, in order.
REQ-038 Full and backpressure: hold out_ready=0 and push 5 commands -> in_ready drops after the 4th queued entry plus the 1 held result; out_z stays stable; releasing out_ready drains all 5 in order.
REQ-039 Full with simultaneous push: with the queue full, raise out_ready and in_valid in the same cycle -> no push that cycle, one pop, and in_ready=1 on the next cycle.
REQ-040 Mid-stream reset: with 3 commands queued, pulse rstn low between edges -> out_valid=0 and in_ready=1 immediately, and no stale result ever appears.
REQ-041 Statistics: with STATS_EN defined, complete 300 operations -> op_count=255; without STATS_EN, op_count=0 throughout.
